// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: arbiter state/request types and counter-width helper shared by dmem_arbiter and arb_sat_counter
package dmem_arb_pkg;
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  typedef enum logic {CORE_OWN, HOST_OWN} arb_state_e;
  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
    logic [2:0]            funct3;
  } mem_req_t;
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/arb_sat_counter.sv
// arb_sat_counter: saturating counter with sync clear (clr+inc loads 1); ports clk, rst (sync active-low), clr, inc, cnt_o
module arb_sat_counter
  import dmem_arb_pkg::*;
#(
  parameter  int MAX = 4,
  localparam int W   = cnt_w(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? W'(inc) : (inc && cnt_q != W'(MAX)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: core-priority data-memory arbiter with starvation-forced host bursts; core_*/host_* request ports, mem_* muxed memory port, clk + sync active-low rst; DMEM_ARB_PERF_EN adds perf_stall_cnt_o/perf_host_cnt_o
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_HOST_WAIT  = 4,
  parameter int HOST_BURST_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_req_i,
  input  logic                  core_we_i,
  input  logic [ADDR_WIDTH-1:0] core_addr_i,
  input  logic [DATA_WIDTH-1:0] core_wdata_i,
  input  logic [2:0]            core_funct3_i,
  output logic [DATA_WIDTH-1:0] core_rdata_o,
  output logic                  core_stall_o,
  input  logic                  host_req_i,
  input  logic                  host_we_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [DATA_WIDTH-1:0] host_wdata_i,
  input  logic [2:0]            host_funct3_i,
  output logic                  host_gnt_o,
  output logic [DATA_WIDTH-1:0] host_rdata_o,
  output logic                  host_rvalid_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [2:0]            mem_funct3_o,
  output logic                  mem_we_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt_o,
  output logic [31:0]           perf_host_cnt_o
`endif
);
  localparam int WW = cnt_w(MAX_HOST_WAIT);
  localparam int BW = cnt_w(HOST_BURST_MAX);
  localparam logic [WW-1:0] WAIT_MAX   = WW'(MAX_HOST_WAIT);
  localparam logic [BW-1:0] BURST_LAST = BW'(HOST_BURST_MAX - 1);
  arb_state_e state_q, state_d;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] burst_cnt;
  logic core_gnt, host_gnt, forced, wait_inc, wait_clr, burst_clr;
  logic host_rvalid_q, host_rvalid_d;
  logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
  mem_req_t mem_req;
  arb_sat_counter #(.MAX(MAX_HOST_WAIT)) u_wait (
    .clk(clk), .rst(rst), .clr(wait_clr), .inc(wait_inc), .cnt_o(wait_cnt)
  );
  // burst_cnt counts grants of the current forced burst; the forcing grant itself loads 1
  arb_sat_counter #(.MAX(HOST_BURST_MAX)) u_burst (
    .clk(clk), .rst(rst), .clr(burst_clr), .inc(host_gnt), .cnt_o(burst_cnt)
  );
  always_comb begin
    forced        = state_q == CORE_OWN && host_req_i && wait_cnt == WAIT_MAX;
    host_gnt      = state_q == HOST_OWN ? host_req_i : host_req_i && (forced || !core_req_i);
    core_gnt      = state_q == CORE_OWN && core_req_i && !host_gnt;
    // the burst ends with the grant that brings burst_cnt up to HOST_BURST_MAX
    state_d       = forced ? (HOST_BURST_MAX == 1 ? CORE_OWN : HOST_OWN)
                  : (state_q == HOST_OWN && host_req_i && burst_cnt != BURST_LAST) ? HOST_OWN : CORE_OWN;
    wait_inc      = core_gnt && host_req_i;
    wait_clr      = host_gnt || state_q == HOST_OWN;
    burst_clr     = state_q == CORE_OWN;
    mem_req.we    = host_gnt ? host_we_i : core_gnt && core_we_i;
    mem_req.addr  = host_gnt ? host_addr_i : core_addr_i;
    mem_req.wdata = host_gnt ? host_wdata_i : core_wdata_i;
    mem_req.funct3 = host_gnt ? host_funct3_i : core_funct3_i;
    host_rvalid_d = host_gnt && !host_we_i;
    host_rdata_d  = host_rvalid_d ? mem_rdata_i : host_rdata_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= CORE_OWN;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end
  assign core_rdata_o  = mem_rdata_i;
  assign core_stall_o  = core_req_i && !core_gnt;
  assign host_gnt_o    = host_gnt;
  assign host_rdata_o  = host_rdata_q;
  assign host_rvalid_o = host_rvalid_q;
  assign mem_addr_o    = mem_req.addr;
  assign mem_wdata_o   = mem_req.wdata;
  assign mem_funct3_o  = mem_req.funct3;
  // no memory writes while reset is asserted, even if a grant is decoded
  assign mem_we_o      = rst && mem_req.we;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d, perf_host_q, perf_host_d;
  always_comb begin
    perf_stall_d = perf_stall_q + 32'(core_stall_o);
    perf_host_d  = perf_host_q + 32'(host_gnt);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_host_q  <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_host_q  <= perf_host_d;
    end
  end
  assign perf_stall_cnt_o = perf_stall_q;
  assign perf_host_cnt_o  = perf_host_q;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic checked against a behavioural arbitration/memory model
module tb_dmem_arbiter;
  localparam int MAX_WAIT  = 4;
  localparam int BURST_MAX = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic c_req = 0, c_we = 0, h_req = 0, h_we = 0;
  logic [31:0] c_addr = 0, c_wdata = 0, h_addr = 0, h_wdata = 0;
  logic [2:0] c_f3 = 0, h_f3 = 0;
  logic [31:0] core_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0] mem_f3;
  logic core_stall, host_gnt, host_rvalid, mem_we;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall, perf_host;
`endif
  logic [31:0] ram [16];
  assign mem_rdata = ram[mem_addr[5:2]];
  always @(posedge clk) if (mem_we) ram[mem_addr[5:2]] <= mem_wdata;
  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .core_req_i(c_req), .core_we_i(c_we), .core_addr_i(c_addr), .core_wdata_i(c_wdata),
    .core_funct3_i(c_f3), .core_rdata_o(core_rdata), .core_stall_o(core_stall),
    .host_req_i(h_req), .host_we_i(h_we), .host_addr_i(h_addr), .host_wdata_i(h_wdata),
    .host_funct3_i(h_f3), .host_gnt_o(host_gnt), .host_rdata_o(host_rdata), .host_rvalid_o(host_rvalid),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_funct3_o(mem_f3), .mem_we_o(mem_we),
    .mem_rdata_i(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .perf_stall_cnt_o(perf_stall), .perf_host_cnt_o(perf_host)
`endif
  );
  int n_checks = 0, n_fail = 0;
  int refusals = 0, burst = 0, exp_perf_stall = 0, exp_perf_host = 0;
  bit exp_rvalid = 0, m_hgnt = 0;
  logic [31:0] exp_rdata = 0;
  logic [31:0] ref_mem [16];
  bit obs_hgnt, obs_stall, obs_rvalid, obs_we;
  logic [31:0] obs_crdata, obs_rdata;
  int first, grants, stalls;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    bit hg, cg;
    int nr, nb;
    @(negedge clk);
    hg = 0; cg = 0; nr = refusals; nb = burst;
    if (burst == 0) begin
      if (h_req && refusals >= MAX_WAIT) begin
        hg = 1; nr = 0; nb = (BURST_MAX == 1) ? 0 : 1;
      end else if (c_req) begin
        cg = 1;
        if (h_req) nr = (refusals < MAX_WAIT) ? refusals + 1 : MAX_WAIT;
      end else if (h_req) begin
        hg = 1; nr = 0;
      end
    end else begin
      nr = 0;
      if (h_req) begin
        hg = 1; nb = (burst + 1 == BURST_MAX) ? 0 : burst + 1;
      end else nb = 0;
    end
    check("host_gnt", host_gnt, hg);
    check("core_stall", core_stall, c_req & !cg);
    check("mem_we", mem_we, rst & (hg ? h_we : cg & c_we));
    check("mem_addr", mem_addr, hg ? h_addr : c_addr);
    check("mem_wdata", mem_wdata, hg ? h_wdata : c_wdata);
    check("mem_funct3", mem_f3, hg ? h_f3 : c_f3);
    check("host_rvalid", host_rvalid, exp_rvalid);
    if (exp_rvalid) check("host_rdata", host_rdata, exp_rdata);
    if (cg && !c_we) check("core_rdata", core_rdata, ref_mem[c_addr[5:2]]);
`ifdef DMEM_ARB_PERF_EN
    check("perf_stall", perf_stall, exp_perf_stall);
    check("perf_host", perf_host, exp_perf_host);
`endif
    obs_hgnt = host_gnt; obs_stall = core_stall; obs_rvalid = host_rvalid;
    obs_we = mem_we; obs_crdata = core_rdata; obs_rdata = host_rdata;
    m_hgnt = hg;
    if (!rst) begin
      refusals = 0; burst = 0; exp_rvalid = 0; exp_rdata = 0;
      exp_perf_stall = 0; exp_perf_host = 0;
    end else begin
      exp_rvalid = hg && !h_we;
      if (exp_rvalid) exp_rdata = ref_mem[h_addr[5:2]];
      if (hg && h_we) ref_mem[h_addr[5:2]] = h_wdata;
      else if (cg && c_we) ref_mem[c_addr[5:2]] = c_wdata;
      refusals = nr; burst = nb;
      exp_perf_stall += int'(c_req & !cg);
      exp_perf_host += int'(hg);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 0; c_req = 0; h_req = 0;
    tick();
    rst = 1;
  endtask
  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i] = 0;
      ref_mem[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    check("rst_rvalid", host_rvalid, 0);
    check("rst_rdata", host_rdata, 0);
    c_req = 1; c_we = 1; c_addr = 32'h100; c_wdata = 32'hDEADBEEF; c_f3 = 3'd2;
    tick();
    c_we = 0;
    tick();
    check("s1_load_data", obs_crdata, 32'hDEADBEEF);
    check("s1_no_stall", obs_stall, 0);
    c_req = 0; h_req = 1; h_we = 0; h_addr = 32'h100; h_f3 = 3'd2;
    tick();
    check("s2_gnt", obs_hgnt, 1);
    h_req = 0;
    tick();
    check("s2_rvalid", obs_rvalid, 1);
    check("s2_rdata", obs_rdata, 32'hDEADBEEF);
    tick();
    check("s2_rvalid_pulse", obs_rvalid, 0);
    do_reset();
    c_req = 1; c_we = 0; h_req = 1; h_we = 0; h_addr = 32'h10;
    first = -1; grants = 0; stalls = 0;
    for (int i = 0; i < 13; i++) begin
      c_addr = 32'($urandom_range(0, 15)) << 2;
      tick();
      if (obs_hgnt) begin
        if (first < 0) first = i;
        grants++;
        h_addr = h_addr + 4;
      end
      stalls += int'(obs_stall);
    end
    check("s3_first_grant", first, 4);
    check("s3_grants", grants, 8);
    check("s3_stalls", stalls, 8);
    check("s3_resume_stall", obs_stall, 0);
`ifdef DMEM_ARB_PERF_EN
    check("s3_perf_stall", perf_stall, 8);
    check("s3_perf_host", perf_host, 8);
`endif
    do_reset();
    c_req = 1; h_req = 1; grants = 0;
    for (int i = 0; i < 20 && grants < 3; i++) begin
      tick();
      if (obs_hgnt) begin
        grants++;
        h_addr = h_addr + 4;
      end
    end
    check("s4_grants", grants, 3);
    h_req = 0;
    tick();
    tick();
    check("s4_resume_stall", obs_stall, 0);
    do_reset();
    c_req = 1; h_req = 1; grants = 0;
    for (int i = 0; i < 20 && grants < 5; i++) begin
      tick();
      if (obs_hgnt) begin
        grants++;
        h_addr = h_addr + 4;
      end
    end
    check("s5_grants", grants, 5);
    rst = 0; c_we = 1; h_we = 1; h_wdata = 32'h5A5A_0001;
    tick();
    check("s5_we_in_reset", obs_we, 0);
    rst = 1; c_we = 0; h_we = 0;
    tick();
    check("s5_core_gnt", obs_stall, 0);
    check("s5_host_refused", obs_hgnt, 0);
    check("s5_rvalid", obs_rvalid, 0);
    h_req = 0;
    for (int i = 0; i < 1500; i++) begin
      rst = $urandom_range(0, 99) != 0;
      c_req = $urandom_range(0, 3) != 0;
      c_we = $urandom_range(0, 1) == 1;
      c_addr = 32'($urandom_range(0, 15)) << 2;
      c_wdata = $urandom;
      c_f3 = 3'($urandom_range(0, 7));
      if (!h_req || m_hgnt) begin
        h_req = $urandom_range(0, 1) == 1;
        h_we = $urandom_range(0, 1) == 1;
        h_addr = 32'($urandom_range(0, 15)) << 2;
        h_wdata = $urandom;
        h_f3 = 3'($urandom_range(0, 7));
      end
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
